// File: rtl/ro_window_sampler.sv
// Ring-oscillator window sampler: gates the RO counter for a programmable window and captures the settled count.
// Latency: start edge -> sample_valid = 1 + CLR_CYCLES + W + SETTLE_CYCLES + 2 clk cycles when the count is stable.
// Backpressure: a held sample waits for sample_ready; a capture that finds the output full is dropped and flags overrun.
module ro_window_sampler #(
  parameter int CNT_WIDTH      = 32,
  parameter int WIN_WIDTH      = 16,
  parameter int CLR_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [WIN_WIDTH-1:0] window_len,
  input  logic [CNT_WIDTH-1:0] ro_count,
  output logic                 ro_enable,
  output logic                 ro_reset,
  output logic [CNT_WIDTH-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 sample_unstbl,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  // The RO gate flops follow state_q, so they trail the FSM by one cycle.
  // SETTLE therefore spans one extra state cycle so that the chain gets a full
  // SETTLE_CYCLES after the gate has actually dropped.
  localparam logic [WIN_WIDTH-1:0] CLR_LAST    = WIN_WIDTH'(CLR_CYCLES - 1);
  localparam logic [WIN_WIDTH-1:0] SETTLE_LAST = WIN_WIDTH'(SETTLE_CYCLES);
  localparam logic [WIN_WIDTH-1:0] TMO_LAST    = WIN_WIDTH'(STABLE_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [WIN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIN_WIDTH-1:0]   win_q, win_d;
  logic [CNT_WIDTH-1:0]   s1_q, s1_d;
  logic [CNT_WIDTH-1:0]   s2_q, s2_d;
  logic [CNT_WIDTH-1:0]   s3_q, s3_d;
  logic                   ro_enable_q, ro_enable_d;
  logic                   ro_reset_q, ro_reset_d;
  logic [CNT_WIDTH-1:0]   sample_data_q, sample_data_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   sample_unstbl_q, sample_unstbl_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic [WIN_WIDTH-1:0]   win_eff;
  logic                   cap_stable;
  logic                   cap_fire;

  assign win_eff    = (window_len == '0) ? WIN_WIDTH'(1) : window_len;
  assign cap_stable = (s2_q == s3_q);
  assign cap_fire   = (state_q == CAPTURE) && (cap_stable || (cnt_q == TMO_LAST));

  // State, timers, synchroniser and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      win_q           <= WIN_WIDTH'(1);
      s1_q            <= '0;
      s2_q            <= '0;
      s3_q            <= '0;
      ro_enable_q     <= 1'b0;
      ro_reset_q      <= 1'b1;
      sample_data_q   <= '0;
      sample_valid_q  <= 1'b0;
      sample_unstbl_q <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      win_q           <= win_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      ro_enable_q     <= ro_enable_d;
      ro_reset_q      <= ro_reset_d;
      sample_data_q   <= sample_data_d;
      sample_valid_q  <= sample_valid_d;
      sample_unstbl_q <= sample_unstbl_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  // Next-state: sequence the window phases and latch the window length on each arm.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d = CLEAR;
          win_d   = win_eff;
        end
      end
      CLEAR:   if (cnt_q == CLR_LAST)              state_d = RUN;
      RUN:     if (cnt_q == win_q - WIN_WIDTH'(1)) state_d = SETTLE;
      SETTLE:  if (cnt_q == SETTLE_LAST)           state_d = CAPTURE;
      CAPTURE: begin
        if (cap_fire) begin
          if (continuous) begin
            state_d = CLEAR;
            win_d   = win_eff;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // One phase timer, restarted on every state change.
    if ((state_q == IDLE) || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIN_WIDTH'(1);
    end
  end

  // Outputs: RO gating, count resynchronisation and the sample stream register.
  always_comb begin
    s1_d            = ro_count;
    s2_d            = s1_q;
    s3_d            = s2_q;
    ro_enable_d     = (state_q == RUN);
    ro_reset_d      = (state_q == IDLE) || (state_q == CLEAR);
    busy_d          = (state_d != IDLE);
    sample_data_d   = sample_data_q;
    sample_valid_d  = sample_valid_q;
    sample_unstbl_d = sample_unstbl_q;
    overrun_d       = overrun_q;
    if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end
    if (cap_fire) begin
      if (!sample_valid_q || sample_ready) begin
        sample_data_d   = s2_q;
        sample_unstbl_d = !cap_stable;
        sample_valid_d  = 1'b1;
      end else begin
        // Output still occupied: keep the held sample, drop this one.
        overrun_d = 1'b1;
      end
    end
  end

  assign ro_enable     = ro_enable_q;
  assign ro_reset      = ro_reset_q;
  assign sample_data   = sample_data_q;
  assign sample_valid  = sample_valid_q;
  assign sample_unstbl = sample_unstbl_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_ro_window_sampler.sv
// Directed bench for ro_window_sampler with a behavioural ring-oscillator counter model.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_ro_window_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] window_len = 16'd10;
  logic [31:0] ro_count;
  logic        ro_enable;
  logic        ro_reset;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        sample_unstbl;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // Ring-oscillator counter model: advances by 'rate' per clk while enabled,
  // or flips its LSB every clk in toggle mode to emulate an unsettled chain.
  logic [31:0] ro_cnt = 32'd0;
  int          rate = 3;
  bit          toggle = 1'b0;
  assign ro_count = ro_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (toggle)         ro_cnt = ro_cnt ^ 32'd1;
    else if (ro_reset)  ro_cnt = 32'd0;
    else if (ro_enable) ro_cnt = ro_cnt + 32'(rate);
  end

  ro_window_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .window_len   (window_len),
    .ro_count     (ro_count),
    .ro_enable    (ro_enable),
    .ro_reset     (ro_reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_unstbl(sample_unstbl),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start (unless arm_cont) and count edges until sample_valid, plus gate-high cycles.
  task automatic measure(input bit arm_cont, output int lat, output int en_cyc);
    lat = 0;
    en_cyc = 0;
    if (arm_cont) continuous = 1'b1;
    else          start = 1'b1;
    do begin
      tick();
      start = 1'b0;
      lat++;
      if (ro_enable) en_cyc++;
    end while (!sample_valid && lat < 200);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int en_cyc;
    int n;
    int vcount;
    bit data_ok;

    // Reset state
    tick();
    tick();
    chk("rst_ro_enable", {31'd0, ro_enable}, 32'd0);
    chk("rst_ro_reset", {31'd0, ro_reset}, 32'd1);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data", sample_data, 32'd0);
    chk("rst_unstbl", {31'd0, sample_unstbl}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick();

    // T1 single shot, W=10, +3/clk: latency 1+2+10+4+2 = 19, count 30
    window_len = 16'd10;
    rate = 3;
    measure(1'b0, lat, en_cyc);
    chk("t1_latency", 32'(lat), 32'd19);
    chk("t1_enable_cycles", 32'(en_cyc), 32'd10);
    chk("t1_data", sample_data, 32'd30);
    chk("t1_unstbl", {31'd0, sample_unstbl}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    window_len = 16'd77;
    repeat (3) tick();
    chk("t1_hold_data", sample_data, 32'd30);
    chk("t1_hold_valid", {31'd0, sample_valid}, 32'd1);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk("t1_valid_clears", {31'd0, sample_valid}, 32'd0);

    // T2 window_len=0 behaves as 1: latency 1+2+1+4+2 = 10, count 3
    window_len = 16'd0;
    measure(1'b0, lat, en_cyc);
    chk("t2_latency", 32'(lat), 32'd10);
    chk("t2_enable_cycles", 32'(en_cyc), 32'd1);
    chk("t2_data", sample_data, 32'd3);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    repeat (20) tick();
    chk("t2_single_sample", {31'd0, sample_valid}, 32'd0);

    // T3 continuous with consumer stalled: first sample held, overrun after 2nd capture
    window_len = 16'd4;
    measure(1'b1, lat, en_cyc);
    rate = 5;
    chk("t3_first_data", sample_data, 32'd12);
    repeat (15) tick();
    chk("t3_overrun", {31'd0, overrun}, 32'd1);
    chk("t3_held_data", sample_data, 32'd12);
    chk("t3_held_valid", {31'd0, sample_valid}, 32'd1);
    sample_ready = 1'b1;
    continuous = 1'b0;
    tick();
    sample_ready = 1'b0;
    n = 0;
    while (!sample_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t3_next_data", sample_data, 32'd20);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    wait_idle("t3_idle_after_stop");

    // T4 count never settles: timeout capture 7 cycles later, flagged unstable
    window_len = 16'd2;
    toggle = 1'b1;
    measure(1'b0, lat, en_cyc);
    toggle = 1'b0;
    chk("t4_latency", 32'(lat), 32'd18);
    chk("t4_unstbl", {31'd0, sample_unstbl}, 32'd1);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;

    // T5 asynchronous reset in the middle of RUN
    window_len = 16'd10;
    rate = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("t5_in_run", {31'd0, ro_enable}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_ro_enable", {31'd0, ro_enable}, 32'd0);
    chk("t5_ro_reset", {31'd0, ro_reset}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
    tick();
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sample_valid) vcount++;
    end
    chk("t5_no_sample", 32'(vcount), 32'd0);

    // T6 back-to-back stream with ready held high, start pulses ignored while busy
    window_len = 16'd3;
    sample_ready = 1'b1;
    continuous = 1'b1;
    vcount = 0;
    data_ok = 1'b1;
    for (int i = 0; i < 55; i++) begin
      start = (i % 4 == 2);
      tick();
      if (sample_valid) begin
        vcount++;
        if (sample_data !== 32'd9) data_ok = 1'b0;
      end
    end
    start = 1'b0;
    continuous = 1'b0;
    chk("t6_sample_count", 32'(vcount), 32'd4);
    chk("t6_data_all_9", {31'd0, data_ok}, 32'd1);
    wait_idle("t6_idle_after_stop");
    chk("t6_no_overrun", {31'd0, overrun}, 32'd0);
    sample_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
